pkt_fifo: RTL and testbench
===========================

PKT_FIFO -- requirements
Module: pkt_fifo

Interface
REQ-001 SHALL have parameter DATA_W, default 8, meaning payload byte width.
REQ-002 SHALL have parameter DEPTH, default 16, meaning buffer entries; power of two, at least 4.
REQ-003 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n  input  1  asynchronous, active-high reset (asserted = 1).
REQ-005 SHALL have port valid_in  input  1  upstream (mux output) beat valid.
REQ-006 SHALL have port last_in  input  1  upstream beat is the final beat of a packet.
REQ-007 SHALL have port data_in  input  DATA_W  upstream beat payload.
REQ-008 SHALL have port ready_out  output  1  this block accepts the beat this cycle.
REQ-009 SHALL have port valid_out  output  1  downstream beat valid.
REQ-010 SHALL have port last_out  output  1  downstream beat is the final beat of a packet.
REQ-011 SHALL have port data_out  output  DATA_W  downstream beat payload.
REQ-012 SHALL have port ready_in  input  1  downstream (sink) accepts the beat.
REQ-013 SHALL have port drop_cnt  output  8  count of discarded oversize packets, saturating at 255.
REQ-014 SHALL have port level  output  log2(DEPTH)+1  entries currently stored, committed plus partial.

Function
REQ-015 SHALL be a store-and-forward packet FIFO: each entry holds {last, data}, and no beat of a packet is presented on the output until its last beat is stored.
REQ-016 SHALL transfer a beat on the input when valid_in && ready_out, and on the output when valid_out && ready_in.
REQ-017 SHALL keep wr_ptr, commit_ptr and rd_ptr, each log2(DEPTH)+1 bits with a wrap bit; full = (wr_ptr - rd_ptr == DEPTH).
REQ-018 SHALL keep pkt_cnt of committed packets: +1 on an accepted stored last_in beat and -1 on an output transfer with last_out; when both occur in one cycle, pkt_cnt stays unchanged.
REQ-019 SHALL set commit_ptr to the incremented wr_ptr on the edge that stores a last_in beat.
REQ-020 SHALL drive valid_out = (pkt_cnt != 0) and {last_out, data_out} = mem[rd_ptr] combinationally; the first beat of a packet appears the cycle after its last beat is accepted.
REQ-021 SHALL hold data_out/last_out stable while valid_out && !ready_in.
REQ-022 SHALL implement a two-state machine, PASS and DROP.
REQ-023 In PASS, ready_out SHALL equal !full || (pkt_cnt == 0).
REQ-024 In PASS with !full, an accepted beat SHALL be written at wr_ptr and wr_ptr SHALL increment.
REQ-025 In PASS with full && pkt_cnt == 0 and valid_in (oversize packet), the beat SHALL be discarded, wr_ptr SHALL rewind to commit_ptr, and drop_cnt SHALL increment; the state SHALL move to DROP unless last_in is 1.
REQ-026 In PASS with full && pkt_cnt != 0, ready_out SHALL be 0 (stall).
REQ-027 In DROP, ready_out SHALL be 1, all beats SHALL be discarded, and the state SHALL return to PASS on the edge that accepts last_in.
REQ-028 A packet of exactly DEPTH beats SHALL be stored and forwarded intact, not dropped.
REQ-029 Reading SHALL free space in the same cycle's full calculation on the following edge only; there is no combinational ready_in to ready_out path.
REQ-030 level SHALL equal wr_ptr - rd_ptr.

Reset
REQ-031 While rst_n = 1, all pointers, pkt_cnt and drop_cnt SHALL be 0, the state SHALL be PASS, valid_out SHALL be 0 and ready_out SHALL be 0.
REQ-032 Reset mid-packet SHALL discard all stored and partial data; after release, the first accepted beat starts a new packet.
REQ-033 Memory contents SHALL need no reset.

Structure
REQ-034 Shared package SHALL hold the PASS/DROP state encoding and the default DATA_W and DEPTH.
REQ-035 The storage array SHALL be one sub-module, pkt_fifo_ram, with one write port and one asynchronous read port.

Verification
REQ-036 4-beat packet 0x01..0x04 with ready_in = 1 -> valid_out rises the cycle after last_in is accepted; output is 01,02,03,04 with last_out on 04.
REQ-037 4-beat and 6-beat packets back-to-back with ready_in = 0 for 20 cycles, then 1 -> level = 10, pkt_cnt = 2; output drains as 10 beats in order with last_out on beats 4 and 10.
REQ-038 16-beat packet with ready_in = 0 -> all accepted, full, ready_out stays 1 (pkt_cnt = 0 until last); later drained intact, drop_cnt = 0.
REQ-039 20-beat packet, then 3-beat packet 0xA0..0xA2 -> beat 17 triggers DROP, drop_cnt = 1, ready_out = 1 through beat 20; only A0,A1,A2 are output.
REQ-040 Committed 10-beat packet, ready_in = 0, then a second 8-beat packet -> ready_out = 0 after 6 beats; after ready_in = 1, everything is delivered with no loss.
REQ-041 rst_n pulsed mid-packet -> valid_out = 0, level = 0; the next 2-beat packet passes unchanged.

Source files
------------

// File: rtl/pkt_fifo_pkg.sv
// Shared definitions for the store-and-forward packet FIFO.
package pkt_fifo_pkg;

  localparam int DEF_DATA_W = 8;
  localparam int DEF_DEPTH  = 16;

  // Input-side packet handling state.
  typedef enum logic {
    ST_PASS = 1'b0,
    ST_DROP = 1'b1
  } state_t;

endpackage : pkt_fifo_pkg

// File: rtl/pkt_fifo_ram.sv
// Packet buffer storage: one synchronous write port, one asynchronous read port.
module pkt_fifo_ram #(
  parameter int WIDTH = 9,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [WIDTH-1:0]         wdata,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output logic [WIDTH-1:0]         rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  // Store one entry per accepted beat.
  // NOTE: storage has no reset; entries are only read once the pointers say they hold valid data.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule : pkt_fifo_ram

// File: rtl/pkt_fifo.sv
// Store-and-forward packet FIFO. A packet becomes visible downstream only once
// its last beat is stored; a packet larger than the whole buffer is discarded
// and counted in drop_cnt. rst_n is an active-high asynchronous reset.
module pkt_fifo
  import pkt_fifo_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int DEPTH  = DEF_DEPTH
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   valid_in,
  input  logic                   last_in,
  input  logic [DATA_W-1:0]      data_in,
  output logic                   ready_out,
  output logic                   valid_out,
  output logic                   last_out,
  output logic [DATA_W-1:0]      data_out,
  input  logic                   ready_in,
  output logic [7:0]             drop_cnt,
  output logic [$clog2(DEPTH):0] level
);

  localparam int AW    = $clog2(DEPTH);
  localparam int PTR_W = AW + 1;
  localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);
  localparam logic [PTR_W-1:0] PTR_CAP = PTR_W'(DEPTH);

  state_t           state, state_nxt;
  logic [PTR_W-1:0] wr_ptr, commit_ptr, rd_ptr;
  logic [PTR_W-1:0] pkt_cnt;
  logic [PTR_W-1:0] used;
  logic             full;
  logic             wr_en;
  logic             rewind;
  logic             commit;
  logic             rd_fire;
  logic             rd_last;
  logic [DATA_W:0]  rd_entry;

  assign used     = wr_ptr - rd_ptr;
  assign full     = (used == PTR_CAP);
  assign level    = used;

  assign valid_out = (pkt_cnt != '0);
  assign last_out  = rd_entry[DATA_W];
  assign data_out  = rd_entry[DATA_W-1:0];

  assign commit  = wr_en && last_in;
  assign rd_fire = valid_out && ready_in;
  assign rd_last = rd_fire && last_out;

  pkt_fifo_ram #(
    .WIDTH (DATA_W + 1),
    .DEPTH (DEPTH)
  ) u_ram (
    .clk   (clk),
    .we    (wr_en),
    .waddr (wr_ptr[AW-1:0]),
    .wdata ({last_in, data_in}),
    .raddr (rd_ptr[AW-1:0]),
    .rdata (rd_entry)
  );

  // Decide acceptance, storage or discard of the incoming beat, and the next state.
  // NOTE: every output of this block gets a default first so no path leaves one unassigned (no latches).
  always_comb begin
    state_nxt = state;
    ready_out = 1'b0;
    wr_en     = 1'b0;
    rewind    = 1'b0;
    if (!rst_n) begin
      unique case (state)
        ST_PASS: begin
          ready_out = !full || (pkt_cnt == '0);
          if (valid_in && ready_out) begin
            if (!full) begin
              wr_en = 1'b1;
            end else begin
              // Buffer filled by a single uncommitted packet: it can never fit.
              rewind = 1'b1;
              if (!last_in) state_nxt = ST_DROP;
            end
          end
        end
        ST_DROP: begin
          ready_out = 1'b1;
          if (valid_in && last_in) state_nxt = ST_PASS;
        end
        default: state_nxt = ST_PASS;
      endcase
    end
  end

  // Pointer, packet count, drop counter and state registers.
  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      state      <= ST_PASS;
      wr_ptr     <= '0;
      commit_ptr <= '0;
      rd_ptr     <= '0;
      pkt_cnt    <= '0;
      drop_cnt   <= '0;
    end else begin
      state <= state_nxt;

      if (wr_en)       wr_ptr <= wr_ptr + PTR_ONE;
      else if (rewind) wr_ptr <= commit_ptr;

      if (commit)  commit_ptr <= wr_ptr + PTR_ONE;
      if (rd_fire) rd_ptr     <= rd_ptr + PTR_ONE;

      unique case ({commit, rd_last})
        2'b10:   pkt_cnt <= pkt_cnt + PTR_ONE;
        2'b01:   pkt_cnt <= pkt_cnt - PTR_ONE;
        default: pkt_cnt <= pkt_cnt;
      endcase

      if (rewind && (drop_cnt != 8'hFF)) drop_cnt <= drop_cnt + 8'd1;
    end
  end

endmodule : pkt_fifo

// File: tb/tb_pkt_fifo.sv
// Directed self-checking bench for pkt_fifo (DATA_W = 8, DEPTH = 16).
module tb_pkt_fifo;

  localparam int DATA_W = 8;
  localparam int DEPTH  = 16;

  logic              clk      = 1'b0;
  logic              rst_n    = 1'b1;
  logic              valid_in = 1'b0;
  logic              last_in  = 1'b0;
  logic [DATA_W-1:0] data_in  = '0;
  logic              ready_in = 1'b0;
  logic              ready_out;
  logic              valid_out;
  logic              last_out;
  logic [DATA_W-1:0] data_out;
  logic [7:0]        drop_cnt;
  logic [4:0]        level;

  int n_pass  = 0;
  int n_total = 0;

  logic [8:0] rx_q  [$];
  logic [8:0] exp_q [$];

  pkt_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .valid_in  (valid_in),
    .last_in   (last_in),
    .data_in   (data_in),
    .ready_out (ready_out),
    .valid_out (valid_out),
    .last_out  (last_out),
    .data_out  (data_out),
    .ready_in  (ready_in),
    .drop_cnt  (drop_cnt),
    .level     (level)
  );

  always #5 clk = ~clk;

  // Record every output transfer as {last, data}; inputs change at posedge+1, so negedge is stable.
  always @(negedge clk) begin
    if (!rst_n && valid_out && ready_in) rx_q.push_back({last_out, data_out});
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic expect_beat(input logic [7:0] d, input logic l);
    exp_q.push_back({l, d});
  endtask

  // Compare everything received since the last call against the expected list, then clear both.
  task automatic check_rx(input string tag);
    int n;
    check({tag, "_len"}, rx_q.size(), exp_q.size());
    n = (rx_q.size() < exp_q.size()) ? rx_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) check($sformatf("%s_beat%0d", tag, i), rx_q[i], exp_q[i]);
    rx_q.delete();
    exp_q.delete();
  endtask

  // Offer one beat and hold it until accepted; returns at posedge+1 after the accepting edge.
  task automatic send(input logic [7:0] d, input logic l);
    int n;
    n        = 0;
    valid_in = 1'b1;
    last_in  = l;
    data_in  = d;
    @(negedge clk);
    while (!ready_out && n < 64) begin
      @(negedge clk);
      n++;
    end
    if (!ready_out) check("send_timeout", n, 0);
    @(posedge clk);
    #1;
    valid_in = 1'b0;
    last_in  = 1'b0;
  endtask

  task automatic idle(input int cycles);
    repeat (cycles) @(posedge clk);
    #1;
  endtask

  initial begin
    // Reset state
    rst_n = 1'b1;
    idle(3);
    check("rst_valid_out", valid_out, 0);
    check("rst_ready_out", ready_out, 0);
    check("rst_level", level, 0);
    check("rst_drop_cnt", drop_cnt, 0);
    rst_n = 1'b0;
    idle(1);
    check("post_rst_ready_out", ready_out, 1);

    // Single 4-beat packet, sink always ready
    ready_in = 1'b1;
    send(8'h01, 0); send(8'h02, 0); send(8'h03, 0);
    check("t1_hold_before_last", valid_out, 0);
    send(8'h04, 1);
    check("t1_valid_after_last", valid_out, 1);
    check("t1_first_data", data_out, 8'h01);
    idle(8);
    for (int i = 1; i <= 4; i++) expect_beat(8'(i), i == 4);
    check_rx("t1_rx");

    // Two packets stored back-to-back behind a stalled sink
    ready_in = 1'b0;
    for (int i = 0; i < 4; i++) send(8'h10 + 8'(i), i == 3);
    for (int i = 0; i < 6; i++) send(8'h20 + 8'(i), i == 5);
    idle(20);
    check("t2_level", level, 10);
    check("t2_pkt_cnt", dut.pkt_cnt, 2);
    check("t2_stall_data", {last_out, data_out}, 9'h010);
    ready_in = 1'b1;
    idle(15);
    for (int i = 0; i < 4; i++) expect_beat(8'h10 + 8'(i), i == 3);
    for (int i = 0; i < 6; i++) expect_beat(8'h20 + 8'(i), i == 5);
    check_rx("t2_rx");
    check("t2_level_drained", level, 0);

    // Packet of exactly DEPTH beats is kept
    ready_in = 1'b0;
    for (int i = 0; i < 16; i++) send(8'h30 + 8'(i), i == 15);
    check("t3_level_full", level, 16);
    check("t3_valid", valid_out, 1);
    check("t3_drop_cnt", drop_cnt, 0);
    ready_in = 1'b1;
    idle(20);
    for (int i = 0; i < 16; i++) expect_beat(8'h30 + 8'(i), i == 15);
    check_rx("t3_rx");

    // Oversize 20-beat packet is dropped, following packet passes
    for (int i = 0; i < 16; i++) send(8'h40 + 8'(i), 0);
    check("t4_level_16", level, 16);
    check("t4_ready_full_no_pkt", ready_out, 1);
    send(8'h50, 0);
    check("t4_drop_cnt", drop_cnt, 1);
    check("t4_level_rewound", level, 0);
    for (int i = 17; i < 20; i++) begin
      check($sformatf("t4_ready_drop_b%0d", i + 1), ready_out, 1);
      send(8'h40 + 8'(i), i == 19);
    end
    check("t4_valid_none", valid_out, 0);
    send(8'hA0, 0); send(8'hA1, 0); send(8'hA2, 1);
    idle(6);
    expect_beat(8'hA0, 0); expect_beat(8'hA1, 0); expect_beat(8'hA2, 1);
    check_rx("t4_rx");
    check("t4_drop_cnt_final", drop_cnt, 1);

    // Committed packet blocks the next one once the buffer fills
    ready_in = 1'b0;
    for (int i = 0; i < 10; i++) send(8'h50 + 8'(i), i == 9);
    for (int i = 0; i < 6; i++) send(8'h60 + 8'(i), 0);
    check("t5_level", level, 16);
    check("t5_stall_ready", ready_out, 0);
    idle(2);
    check("t5_stall_ready_hold", ready_out, 0);
    ready_in = 1'b1;
    send(8'h66, 0); send(8'h67, 1);
    idle(25);
    for (int i = 0; i < 10; i++) expect_beat(8'h50 + 8'(i), i == 9);
    for (int i = 0; i < 8; i++) expect_beat(8'h60 + 8'(i), i == 7);
    check_rx("t5_rx");
    check("t5_drop_cnt", drop_cnt, 1);

    // Reset in the middle of a packet
    send(8'h70, 0); send(8'h71, 0);
    rst_n = 1'b1;
    #1;
    check("t6_rst_valid", valid_out, 0);
    check("t6_rst_level", level, 0);
    check("t6_rst_ready", ready_out, 0);
    idle(1);
    rst_n = 1'b0;
    rx_q.delete();
    idle(1);
    check("t6_drop_cnt_cleared", drop_cnt, 0);
    send(8'h80, 0); send(8'h81, 1);
    idle(5);
    expect_beat(8'h80, 0); expect_beat(8'h81, 1);
    check_rx("t6_rx");

    // drop_cnt saturates at 255
    for (int k = 0; k < 260; k++)
      for (int i = 0; i < 17; i++) send(8'(i), i == 16);
    check("t7_drop_sat", drop_cnt, 255);
    check("t7_level", level, 0);
    check_rx("t7_rx");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule : tb_pkt_fifo
